// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage feeding decode (optional stall counter: FETCH_STALL_CNT_EN)
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic [31:0] Mem_Rdata,
   input  logic        Mem_Ack,
   output logic [31:0] Instr,
   output logic [31:0] Instr_PC,
   output logic        Instr_Valid,
   input  logic        Instr_Ready,
   input  logic [31:0] Immed,
   input  logic        Br_Taken,
   output logic [31:0] Stall_Cnt
);
   typedef enum logic [1:0] {IDLE, FETCH, HAVE} state_t;
   state_t      state;
   logic [31:0] pc;
   assign Mem_Addr = pc;
   // fetch/hold/consume sequencing; pc already points past Instr while in HAVE, so a branch adds Immed to it
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         Instr       <= '0;
         Instr_PC    <= '0;
         Instr_Valid <= 1'b0;
         Mem_Req     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state   <= FETCH;
               Mem_Req <= 1'b1;
            end
            FETCH:
               if (Mem_Ack) begin
                  Instr       <= Mem_Rdata;
                  Instr_PC    <= pc;
                  pc          <= (pc + 32'd4) & ~32'd3;
                  Instr_Valid <= 1'b1;
                  Mem_Req     <= 1'b0;
                  state       <= HAVE;
               end
            HAVE:
               if (Instr_Ready) begin
                  pc          <= Br_Taken ? (pc + Immed) & ~32'd3 : pc;
                  Instr_Valid <= 1'b0;
                  Mem_Req     <= 1'b1;
                  state       <= FETCH;
               end
            default: state <= IDLE;
         endcase
      end
`ifdef FETCH_STALL_CNT_EN
   logic stall;
   assign stall = (state == FETCH && !Mem_Ack) || (state == HAVE && !Instr_Ready);
   // saturating count of cycles waiting on memory or on decode
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) Stall_Cnt <= '0;
      else if (stall && ~&Stall_Cnt) Stall_Cnt <= Stall_Cnt + 32'd1;
`else
   assign Stall_Cnt = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus against a transaction-level fetch model
module tb_instr_fetch;
   localparam logic [31:0] RPC = 32'h0000_0000;
   logic        Clk = 1'b0, Reset_n = 1'b0;
   logic        Mem_Req, Mem_Ack = 1'b0, Instr_Valid, Instr_Ready = 1'b0, Br_Taken = 1'b0;
   logic [31:0] Mem_Addr, Mem_Rdata = '0, Instr, Instr_PC, Immed = '0, Stall_Cnt;
   int errors = 0, checks = 0;
   logic        m_idle, m_req, m_valid;
   logic [31:0] m_pc, m_instr, m_ipc, m_stall;

   instr_fetch #(.RESET_PC(RPC)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
      .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack), .Instr(Instr), .Instr_PC(Instr_PC),
      .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Immed(Immed),
      .Br_Taken(Br_Taken), .Stall_Cnt(Stall_Cnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("mem_req", {31'b0, Mem_Req}, {31'b0, m_req});
      if (m_req) chk("mem_addr", Mem_Addr, m_pc);
      chk("instr_valid", {31'b0, Instr_Valid}, {31'b0, m_valid});
      chk("instr", Instr, m_instr);
      chk("instr_pc", Instr_PC, m_ipc);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt", Stall_Cnt, m_stall);
`else
      chk("stall_cnt", Stall_Cnt, 32'd0);
`endif
   endtask

   task automatic model_reset();
      m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0;
      m_pc = RPC; m_instr = '0; m_ipc = '0; m_stall = '0;
   endtask

   // one clock: drive inputs, advance the model by the spec's rules, then compare after the edge
   task automatic cycle(input logic ack, input logic rdy, input logic br, input logic [31:0] imm);
      Mem_Ack = ack; Instr_Ready = rdy; Br_Taken = br; Immed = imm;
      Mem_Rdata = 32'hA000_0000 + m_pc;
      if (m_idle) begin
         m_idle = 1'b0; m_req = 1'b1;
      end else if (m_req) begin
         if (!ack) m_stall = m_stall + {31'b0, m_stall != 32'hFFFF_FFFF};
         else begin
            m_instr = Mem_Rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
            m_valid = 1'b1; m_req = 1'b0;
         end
      end else if (!rdy) m_stall = m_stall + {31'b0, m_stall != 32'hFFFF_FFFF};
      else begin
         if (br) m_pc = (m_ipc + 32'd4 + imm) & ~32'd3;
         m_valid = 1'b0; m_req = 1'b1;
      end
      @(posedge Clk); #1;
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge Clk);
      #1 check_all();
      Reset_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, '0);
      chk("first_addr", Mem_Addr, RPC);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0);
         chk("seq_instr", Instr, 32'hA000_0000 + 32'(i * 4));
         chk("seq_pc", Instr_PC, 32'(i * 4));
         if (i < 2) cycle(1'b1, 1'b1, 1'b0, '0);
      end
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0010);
      chk("br_fwd", Mem_Addr, 32'h0000_001C);
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0020);
      cycle(1'b1, 1'b1, 1'b0, '0);
      chk("at_40", Instr_PC, 32'h0000_0040);
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0);
      chk("br_back", Mem_Addr, 32'h0000_0034);
      cycle(1'b1, 1'b0, 1'b0, '0);
      repeat (5) cycle(1'b1, 1'b0, 1'b1, $urandom);
      cycle(1'b1, 1'b1, 1'b0, '0);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
      cycle(1'b1, 1'b1, 1'b0, '0);
      chk("late_ack_pc", Instr_PC, 32'h0000_0038);
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFC0);
      chk("br_top", Mem_Addr, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      chk("wrap", Mem_Addr, 32'h0000_0000);
      repeat (400)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if (m_valid) cycle(1'b0, 1'b1, 1'b0, '0);
      Mem_Ack = 1'b1;
      Reset_n = 1'b0;
      model_reset();
      #1 check_all();
      chk("rst_addr", Mem_Addr, RPC);
      @(posedge Clk); #1;
      check_all();
      Reset_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      chk("post_rst_instr", Instr, 32'hA000_0000 + RPC);
      chk("post_rst_pc", Instr_PC, RPC);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the program counter and issues one request at a time over a req/ack instruction-memory interface.
- Registers the returned word into an instruction register and presents it to decode with a valid/ready handshake.
- Computes the next PC as PC+4 or branch target (PC+4+Immed), using the sign-extended, pre-shifted Immed that decode returns.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Mem_Req  out  1  instruction-memory request; held high until Mem_Ack.
- Mem_Addr  out  32  fetch address; equals PC and is stable while Mem_Req=1.
- Mem_Rdata  in  32  instruction word; valid in the cycle Mem_Ack=1.
- Mem_Ack  in  1  memory completion strobe; sampled only while Mem_Req=1.
- Instr  out  32  registered instruction to decode.
- Instr_PC  out  32  address of the word currently in Instr.
- Instr_Valid  out  1  Instr holds an unconsumed instruction.
- Instr_Ready  in  1  decode accepts Instr this cycle.
- Immed  in  32  branch offset from decode, already sign-extended and shifted left by 2.
- Br_Taken  in  1  branch taken for the instruction being accepted.
- Stall_Cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, Reset_n=0) forces:
  - PC=RESET_PC, Instr=0, Instr_PC=0, Instr_Valid=0, Mem_Req=0, Stall_Cnt=0, state=IDLE.
  - This holds mid-request. The abandoned request is dropped, and any Mem_Ack arriving after reset releases is ignored unless Mem_Req=1.
- IDLE: entered only from reset. Mem_Req=0. The state moves to FETCH on the first rising edge after Reset_n is released.
- FETCH:
  - Mem_Req=1, Mem_Addr=PC, Instr_Valid=0.
  - On an edge with Mem_Ack=1:
    - Instr<=Mem_Rdata, Instr_PC<=PC, PC<=PC+4.
    - Instr_Valid<=1, Mem_Req<=0, state<=HAVE.
  - Mem_Ack may be high in the first FETCH cycle, giving minimum fetch latency of 1 cycle.
- HAVE:
  - Instr_Valid=1, Mem_Req=0.
  - Instr_Ready=0: Instr, Instr_PC and PC are held unchanged (stall).
  - Instr_Ready=1 and Br_Taken=0: the instruction is consumed; PC unchanged (already PC+4); state<=FETCH.
  - Instr_Ready=1 and Br_Taken=1: PC<=PC+Immed, which equals Instr_PC+4+Immed; state<=FETCH.
  - In both consume cases Instr_Valid<=0 on the same edge.
- Throughput: 1 instruction per 2 cycles at best (FETCH, HAVE); no prefetch, no overlap.
- Br_Taken and Immed are ignored unless Instr_Valid=1 and Instr_Ready=1.
- Arithmetic:
  - All PC sums are 32-bit modulo 2^32. Wrap-around is silent: PC=32'hFFFF_FFFC +4 -> 0.
  - Immed is added as two's complement.
  - Bits [1:0] of any new PC are forced to 00.
- Instr is held stable while Instr_Valid=1 and Instr_Ready=0.
- Mem_Addr does not change while Mem_Req=1.
- Mem_Ack while Mem_Req=0 has no effect.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- With it defined, Stall_Cnt is a 32-bit saturating counter that increments on each rising edge where either:
  - state=FETCH and Mem_Ack=0, or
  - state=HAVE and Instr_Ready=0.
- The counter saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Without the macro, Stall_Cnt is constant 0 and no counter logic is built.

Test Plan:
- Release reset, RESET_PC=0, memory acks every request in 1 cycle returning 32'hA000_0000+addr, Instr_Ready=1, Br_Taken=0 -> Instr sequence A000_0000, A000_0004, A000_0008; Instr_PC 0, 4, 8; Instr_Valid pulses every other cycle.
- Instr_PC=8, Immed=32'h0000_0010, Br_Taken=1 at accept -> next Mem_Addr=32'h0000_001C.
- Instr_PC=32'h40, Immed=32'hFFFF_FFF0 (-16), Br_Taken=1 -> next Mem_Addr=32'h34.
- Hold Instr_Ready=0 for 5 cycles in HAVE -> Instr and Instr_PC unchanged, Mem_Req=0 throughout; with FETCH_STALL_CNT_EN, Stall_Cnt=5.
- Mem_Ack delayed 3 cycles -> Mem_Req and Mem_Addr stable for 4 cycles; Br_Taken=1 while Instr_Valid=0 has no effect on PC.
- Reset_n low for 1 cycle mid-FETCH with Mem_Ack high in the same cycle -> Mem_Req=0, Instr_Valid=0, PC=RESET_PC immediately; the next fetch is from RESET_PC; the late Ack is ignored.
